// File: rtl/spi_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_responder : SPI mode-0 target with oversampled pins and fixed frames  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module spi_responder #(
  parameter int SIZE        = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            sck_in,
  input  logic            cs_n_in,
  input  logic            mosi_in,
  output logic            miso_out,
  output logic            r_miso_oe_out,
  input  logic [SIZE-1:0] data_in,
  output logic [SIZE-1:0] r_data_out,
  output logic            r_valid_out,
  output logic            r_error_out,
  output logic            r_busy_out
);

  localparam int            CW     = $clog2(SIZE + 2);
  localparam logic [CW-1:0] C_SIZE = CW'(SIZE);
  localparam logic [CW-1:0] C_SAT  = CW'(SIZE + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SIZE-1:0]   tx_q, tx_d, rx_q, rx_d, data_q, data_d;
  logic              valid_q, valid_d, error_q, error_d;
  logic              busy_q, busy_d, oe_q, oe_d;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  // Synchronizers reset to the idle line levels so release never looks like an edge on sck.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= (sck_sync_q << 1) | SYNC_STAGES'(sck_in);
      cs_sync_q   <= (cs_sync_q << 1) | SYNC_STAGES'(cs_n_in);
      mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(mosi_in);
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      oe_q    <= oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    busy_d  = busy_q;
    oe_d    = oe_q;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          tx_d    = data_in;
          rx_d    = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          oe_d    = 1'b1;
        end
      end
      ACTIVE: begin
        // Deselect wins over any sck edge seen in the same cycle.
        if (cs_rise) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          oe_d    = 1'b0;
          if (cnt_q == C_SIZE) begin
            data_d  = rx_q;
            valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end else begin
          if (sck_rise) begin
            rx_d = {rx_q[SIZE-2:0], mosi_s};
            if (cnt_q != C_SAT) cnt_d = cnt_q + 1'b1;
          end
          if (sck_fall) tx_d = {tx_q[SIZE-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign miso_out      = oe_q & tx_q[SIZE-1];
  assign r_miso_oe_out = oe_q;
  assign r_data_out    = data_q;
  assign r_valid_out   = valid_q;
  assign r_error_out   = error_q;
  assign r_busy_out    = busy_q;

endmodule
`default_nettype wire

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 Parameter SIZE, default 40: frame length in bits, MSB first.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on sck_in, cs_n_in and mosi_in.
REQ-003 clk_in  input  1  system clock; all logic is in this domain; clk_in frequency SHALL be at least 8x sck_in frequency.
REQ-004 reset_in  input  1  reset, asynchronous and active-high.
REQ-005 sck_in  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-006 cs_n_in  input  1  chip select, active low.
REQ-007 mosi_in  input  1  serial data from the initiator.
REQ-008 miso_out  output  1  serial data to the initiator.
REQ-009 r_miso_oe_out  output  1  MISO output enable, high while selected.
REQ-010 data_in  input  SIZE  reply word, sampled at frame start.
REQ-011 r_data_out  output  SIZE  last complete received word.
REQ-012 r_valid_out  output  1  one-cycle pulse when r_data_out is updated.
REQ-013 r_error_out  output  1  one-cycle pulse on a frame with bit count != SIZE.
REQ-014 r_busy_out  output  1  high while a frame is in progress.

Function
REQ-015 sck_in, cs_n_in and mosi_in SHALL each pass through SYNC_STAGES flops; edge detection SHALL compare the last synchronized stage with one further flop, so a pin edge is acted on 3 clk_in cycles later (SYNC_STAGES=2).
REQ-016 FSM states: IDLE and ACTIVE.
REQ-017 IDLE -> ACTIVE on a detected cs_n falling edge: load shift_tx <= data_in, clear bit counter and shift_rx, set r_busy_out and r_miso_oe_out.
REQ-018 In ACTIVE, miso_out SHALL equal shift_tx[SIZE-1] from the cycle after entry onward, so the MSB is valid before the first sck rise.
REQ-019 On each detected sck rising edge in ACTIVE: shift_rx <= {shift_rx[SIZE-2:0], synchronized mosi}; the bit counter increments and saturates at SIZE+1.
REQ-020 On each detected sck falling edge in ACTIVE: shift_tx <= {shift_tx[SIZE-2:0], 1'b0}; after SIZE bits miso_out therefore drives 0.
REQ-021 ACTIVE -> IDLE on a detected cs_n rising edge: clear r_busy_out and r_miso_oe_out in the same cycle.
REQ-022 At that ACTIVE -> IDLE transition, if the counter == SIZE: r_data_out <= shift_rx and r_valid_out pulses high for exactly one cycle; otherwise r_data_out is held and r_error_out pulses for one cycle.
REQ-023 A frame of zero bits (select and deselect with no sck edges) SHALL produce an r_error_out pulse.
REQ-024 sck edges while in IDLE SHALL be ignored.
REQ-025 data_in changes during ACTIVE SHALL NOT affect the frame in progress.
REQ-026 Simultaneous cs_n rise and sck edge detected in the same cycle: cs_n takes priority and the sck edge is discarded.
REQ-027 r_valid_out and r_error_out SHALL never be high in the same cycle.
REQ-028 miso_out SHALL be 0 whenever r_miso_oe_out is low.

Reset
REQ-029 reset_in high SHALL asynchronously force IDLE, counter=0, shift registers=0, r_data_out=0, r_valid_out=0, r_error_out=0, r_busy_out=0, r_miso_oe_out=0 and miso_out=0.
REQ-030 Synchronizer flops SHALL reset to the idle line levels: sck=0, cs_n=1, mosi=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame without any valid or error pulse; after release, the block waits for a new cs_n falling edge.

Verification
REQ-032 SIZE=40, data_in=40'hA5_1234_5678, initiator sends 40'hC3_DEAD_BEEF -> miso sampled on sck rises = A5_1234_5678, r_data_out=C3_DEAD_BEEF, r_valid_out high exactly 1 cycle.
REQ-033 Frame with 39 bits, then a frame with 41 bits -> r_error_out pulses once per frame, r_data_out unchanged, no r_valid_out.
REQ-034 cs_n toggled with no sck edges -> one r_error_out pulse; r_busy_out high only between the detected edges.
REQ-035 reset_in pulsed after 20 bits -> all outputs 0 immediately; a following full frame with 40'h00_0000_0001 -> r_data_out=40'h00_0000_0001.
REQ-036 data_in changed to 40'hFF_FFFF_FFFF after bit 5 of a frame loaded with 40'h0 -> all 40 miso bits = 0.
REQ-037 sck run at clk_in/8 with cs_n rise in the same cycle as the final sck fall -> r_valid_out still asserted, counter = 40.
